demux_router: RTL and testbench

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router_if.sv | 38 +++
 rtl/demux_router.sv | 128 ++++++++++++
 tb/tb_demux_router.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demux_router_if.sv
// demux_router_if: handshake bundle between an upstream producer and the
// demux_router, plus the shared downstream bus with per-destination
// valid/ready. The slave modport is the router's view; master is the
// environment's view.
interface demux_router_if #(
    parameter int switch_bits = 1,
    parameter int data_width  = 8
);
    localparam int N = 1 << switch_bits;

    logic                   in_valid;
    logic                   in_ready;
    logic [switch_bits-1:0] sel;
    logic [data_width-1:0]  data_IN;
    logic [N-1:0]           out_valid;
    logic [N-1:0]           out_ready;
    logic [data_width-1:0]  data_OUT;

    modport master (
        output in_valid,
        output sel,
        output data_IN,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_OUT
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  data_IN,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_OUT
    );
endinterface

// File: rtl/demux_router.sv
// demux_router: 1-to-N demultiplexer with a two-entry (main + skid) buffer.
// Words leave in acceptance order on a shared data bus; out_valid is one-hot
// on the destination. in_ready is registered, so there is no combinational
// path from any out_ready to in_ready.
// Optional feature: define DEMUX_XFER_CNT_EN to add the 16-bit xfer_cnt
// port counting accepted words (wraps at 16'hFFFF).
module demux_router #(
    parameter int switch_bits = 1,
    parameter int data_width  = 8
) (
    input  logic        clk,
    input  logic        rst,
    demux_router_if.slave bus
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [15:0] xfer_cnt
`endif
);
    localparam int N = 1 << switch_bits;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_in_ready;
    logic [N-1:0]           r_out_valid;
    logic [data_width-1:0]  r_main_data;
    logic [data_width-1:0]  r_skid_data;
    logic [switch_bits-1:0] r_skid_sel;

    logic [N-1:0]           w_in_onehot;
    logic [N-1:0]           w_skid_onehot;
    logic                   w_in_fire;
    logic                   w_out_fire;

    // Destination decoders for the incoming word and the skid entry.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign w_in_onehot[gi]   = (bus.sel    == switch_bits'(gi));
            assign w_skid_onehot[gi] = (r_skid_sel == switch_bits'(gi));
        end
    endgenerate

    // Only the ready bit of the selected destination matters, since
    // out_valid has at most one bit set.
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = |(r_out_valid & bus.out_ready);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_OUT  = r_main_data;

    // Buffer FSM; out_valid and in_ready are kept as registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= '0;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_main_data <= bus.data_IN;
                        r_out_valid <= w_in_onehot;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= bus.data_IN;
                        r_out_valid <= w_in_onehot;
                        r_in_ready  <= 1'b1;
                    end else if (w_out_fire) begin
                        r_out_valid <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_EMPTY;
                    end else if (w_in_fire) begin
                        // Main is stalled: park the new word and stop accepting.
                        r_skid_data <= bus.data_IN;
                        r_skid_sel  <= bus.sel;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_SKID;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end
                S_SKID: begin
                    if (w_out_fire) begin
                        r_main_data <= r_skid_data;
                        r_out_valid <= w_skid_onehot;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_FULL;
                    end else begin
                        r_in_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= '0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Count every accepted word; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xfer_cnt <= 16'd0;
        end else if (w_in_fire) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: directed self-checking bench for demux_router with
// switch_bits = 2, data_width = 8. Inputs change 1 time unit after posedge
// clk; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_demux_router;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    demux_router_if #(.switch_bits(2), .data_width(8)) bus ();

`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    demux_router #(.switch_bits(2), .data_width(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .xfer_cnt (xfer_cnt)
    );
`else
    demux_router #(.switch_bits(2), .data_width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
        bus.in_valid = v;
        bus.sel      = s;
        bus.data_IN  = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.out_ready = 4'b0000;
        drive(1'b0, 2'd0, 8'h00);

        // Reset state
        #2;
        check("rst out_valid", 32'(bus.out_valid), 32'h0);
        check("rst in_ready", 32'(bus.in_ready), 32'h0);
        check("rst data_OUT", 32'(bus.data_OUT), 32'h0);
`ifdef DEMUX_XFER_CNT_EN
        check("rst xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
        step();
        rst = 1'b1;
        step();
        check("in_ready after release", 32'(bus.in_ready), 32'h1);

        // Single word to destination 2
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'd2, 8'hA5);
        step();
        drive(1'b0, 2'd1, 8'hFF);   // sel/data must be ignored while idle
        check("single out_valid", 32'(bus.out_valid), 32'h4);
        check("single data", 32'(bus.data_OUT), 32'hA5);
        step();
        check("single drained", 32'(bus.out_valid), 32'h0);

        // Back-pressure into the skid register
        bus.out_ready = 4'b0000;
        drive(1'b1, 2'd1, 8'h11);
        step();
        check("bp first out_valid", 32'(bus.out_valid), 32'h2);
        check("bp in_ready after first", 32'(bus.in_ready), 32'h1);
        drive(1'b1, 2'd3, 8'h22);
        step();
        drive(1'b1, 2'd0, 8'h99);   // offered while full: must not be accepted
        check("bp in_ready after second", 32'(bus.in_ready), 32'h0);
        check("bp hold out_valid", 32'(bus.out_valid), 32'h2);
        step();
        drive(1'b0, 2'd0, 8'h00);
        check("bp hold2 out_valid", 32'(bus.out_valid), 32'h2);
        check("bp hold2 data", 32'(bus.data_OUT), 32'h11);
        bus.out_ready = 4'b1111;
        step();
        check("bp second out_valid", 32'(bus.out_valid), 32'h8);
        check("bp second data", 32'(bus.data_OUT), 32'h22);
        check("bp in_ready restored", 32'(bus.in_ready), 32'h1);
        step();
        check("bp drained", 32'(bus.out_valid), 32'h0);

        // Throughput: one word per cycle, sel cycling 0..3
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'(i % 4), 8'(8'h40 + i));
            step();
            check($sformatf("tp%0d out_valid", i), 32'(bus.out_valid), 32'(4'b0001 << (i % 4)));
            check($sformatf("tp%0d data", i), 32'(bus.data_OUT), 32'(8'h40 + i));
            check($sformatf("tp%0d in_ready", i), 32'(bus.in_ready), 32'h1);
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        check("tp drained", 32'(bus.out_valid), 32'h0);

        // Selective stall: destination 0 not ready blocks destination 1 behind it
        bus.out_ready = 4'b1110;
        drive(1'b1, 2'd0, 8'h77);
        step();
        drive(1'b1, 2'd1, 8'h88);
        step();
        drive(1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d out_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("stall%0d data", i), 32'(bus.data_OUT), 32'h77);
            step();
        end
        bus.out_ready = 4'b1111;
        step();
        check("stall release out_valid", 32'(bus.out_valid), 32'h2);
        check("stall release data", 32'(bus.data_OUT), 32'h88);
        step();
        check("stall drained", 32'(bus.out_valid), 32'h0);

        // Reset asserted mid-transfer with two words held
        bus.out_ready = 4'b0000;
        drive(1'b1, 2'd3, 8'hC3);
        step();
        drive(1'b1, 2'd2, 8'hD4);
        step();
        drive(1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst in_ready", 32'(bus.in_ready), 32'h0);
        check("midrst data_OUT", 32'(bus.data_OUT), 32'h0);
`ifdef DEMUX_XFER_CNT_EN
        check("midrst xfer_cnt", 32'(xfer_cnt), 32'h0);
`endif
        step();
        rst = 1'b1;
        bus.out_ready = 4'b1111;
        step();
        check("post-rst in_ready", 32'(bus.in_ready), 32'h1);
        check("post-rst out_valid", 32'(bus.out_valid), 32'h0);
        step();
        check("post-rst no word", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_XFER_CNT_EN
        // Counter wrap: 65535 fires then one more
        drive(1'b1, 2'd1, 8'h5A);
        repeat (65535) @(posedge clk);
        #1;
        check("cnt preload", 32'(xfer_cnt), 32'hFFFF);
        step();
        check("cnt wrap", 32'(xfer_cnt), 32'h0);
        drive(1'b0, 2'd0, 8'h00);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
